sram_rsp: RTL

SRAM_RSP -- requirements
Module: sram_rsp

---
 rtl/sram_rsp.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/sram_rsp.sv
// ============================================================================
// Module   : sram_rsp
// Purpose  : Asynchronous-SRAM-style responder with latency-timed reads,
//            byte-lane writes committed on we_n rise, and optional protocol
//            checker (enable with SRAM_RSP_ERRCHK_EN).
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module sram_rsp #(
  parameter int ADDR_W = 12,
  parameter int LAT    = 2
) (
  input  logic              clk,
  input  logic              nreset,
  input  logic              ce_n,
  input  logic              oe_n,
  input  logic              we_n,
  input  logic              ub_n,
  input  logic              lb_n,
  input  logic [ADDR_W-1:0] addr,
  input  logic [15:0]       dq_in,
  output logic [15:0]       dq_out,
  output logic [1:0]        dq_oe,
  output logic              busy
`ifdef SRAM_RSP_ERRCHK_EN
  ,
  output logic              err
`endif
);

  localparam int         DEPTH  = 1 << ADDR_W;
  localparam logic [3:0] LAT_M1 = 4'(LAT - 1);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] RWAIT  = 2'd1;
  localparam logic [1:0] RDRIVE = 2'd2;
  localparam logic [1:0] WRITE  = 2'd3;

  logic [15:0]       mem [DEPTH];
  logic [1:0]        state;
  logic [3:0]        cnt;
  logic [ADDR_W-1:0] rd_addr;
  logic [ADDR_W-1:0] wr_addr;
  logic [15:0]       wr_data;
  logic [1:0]        wr_lanes;

  logic       wr_req;
  logic       rd_req;
  logic       commit;
  logic [1:0] lanes;

  assign wr_req = !ce_n && !we_n;
  assign rd_req = !ce_n && !oe_n && we_n;
  assign commit = (state == WRITE) && !wr_req;
  assign lanes  = {~ub_n, ~lb_n};
  assign busy   = (state != IDLE);

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state    <= IDLE;
      cnt      <= 4'd0;
      dq_out   <= 16'd0;
      dq_oe    <= 2'b00;
      rd_addr  <= '0;
      wr_addr  <= '0;
      wr_data  <= 16'd0;
      wr_lanes <= 2'b00;
    end else if (wr_req) begin
      state    <= WRITE;
      cnt      <= 4'd0;
      wr_addr  <= addr;
      wr_data  <= dq_in;
      wr_lanes <= lanes;
      dq_oe    <= 2'b00;
      dq_out   <= 16'd0;
    end else begin
      case (state)
        // A read arriving on the commit cycle starts immediately; the commit
        // lands in mem before any read data is sampled.
        IDLE, WRITE: begin
          dq_oe  <= 2'b00;
          dq_out <= 16'd0;
          if (rd_req) begin
            state   <= RWAIT;
            cnt     <= LAT_M1;
            rd_addr <= addr;
          end else begin
            state <= IDLE;
          end
        end
        RWAIT: begin
          if (!rd_req) begin
            state  <= IDLE;
            dq_oe  <= 2'b00;
            dq_out <= 16'd0;
          end else if (addr != rd_addr) begin
            cnt     <= LAT_M1;
            rd_addr <= addr;
          end else if (cnt == 4'd0) begin
            state  <= RDRIVE;
            dq_oe  <= lanes;
            dq_out <= (lanes != 2'b00) ? mem[addr] : 16'd0;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        RDRIVE: begin
          if (!rd_req) begin
            state  <= IDLE;
            dq_oe  <= 2'b00;
            dq_out <= 16'd0;
          end else if (addr != rd_addr) begin
            state   <= RWAIT;
            cnt     <= LAT_M1;
            rd_addr <= addr;
            dq_oe   <= 2'b00;
            dq_out  <= 16'd0;
          end else begin
            dq_oe  <= lanes;
            dq_out <= (lanes != 2'b00) ? mem[addr] : 16'd0;
          end
        end
        default: begin
          state  <= IDLE;
          dq_oe  <= 2'b00;
          dq_out <= 16'd0;
        end
      endcase
    end
  end

  // Reset forces state to IDLE asynchronously, so a pending write never commits.
  always_ff @(posedge clk) begin
    if (commit) begin
      if (wr_lanes[1]) mem[wr_addr][15:8] <= wr_data[15:8];
      if (wr_lanes[0]) mem[wr_addr][7:0]  <= wr_data[7:0];
    end
  end

`ifdef SRAM_RSP_ERRCHK_EN
  localparam logic [3:0] LAT_C = 4'(LAT);

  logic [3:0] pulse;

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      err   <= 1'b0;
      pulse <= 4'd0;
    end else begin
      if (wr_req) begin
        if (state != WRITE)      pulse <= 4'd1;
        else if (pulse != 4'hF)  pulse <= pulse + 4'd1;
      end
      if ((wr_req && (state == WRITE) && (addr != wr_addr)) ||
          (commit && (pulse < LAT_C)) ||
          (wr_req && !oe_n))
        err <= 1'b1;
    end
  end
`endif

endmodule

`default_nettype wire
